vregs_exenum_seq: RTL and testbench

//  Sequencer that owns and steps the En_ExEnum register (m_exenum_r) through
//  ONE -> TWO -> FIVE -> FOURTEEN -> ONE, holding each value for a

---
 rtl/vregs_exenum_seq_pkg.sv | 34 +++
 rtl/vregs_exenum_ascii.sv | 20 ++
 rtl/vregs_exenum_seq.sv | 100 ++++++++++
 tb/tb_vregs_exenum_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vregs_exenum_seq_pkg.sv
// Shared En_ExEnum encodings, legality check and the sequencing order
// (ONE -> TWO -> FIVE -> FOURTEEN -> ONE) used by the sequencer and its consumers.
package vregs_exenum_seq_pkg;

    typedef enum logic [3:0] {
        EP_ExEnum_ONE      = 4'd1,
        EP_ExEnum_TWO      = 4'd2,
        EP_ExEnum_FIVE     = 4'd5,
        EP_ExEnum_FOURTEEN = 4'd14
    } ex_enum_e;

    localparam int unsigned DWELL_W_DEFAULT = 8;

    function automatic logic exenum_legal(input logic [3:0] v);
        case (v)
            EP_ExEnum_ONE,
            EP_ExEnum_TWO,
            EP_ExEnum_FIVE,
            EP_ExEnum_FOURTEEN: exenum_legal = 1'b1;
            default:            exenum_legal = 1'b0;
        endcase
    endfunction

    // Illegal encodings (X/SEU only) recover to ONE.
    function automatic ex_enum_e exenum_next(input logic [3:0] v);
        case (v)
            EP_ExEnum_ONE:  exenum_next = EP_ExEnum_TWO;
            EP_ExEnum_TWO:  exenum_next = EP_ExEnum_FIVE;
            EP_ExEnum_FIVE: exenum_next = EP_ExEnum_FOURTEEN;
            default:        exenum_next = EP_ExEnum_ONE;
        endcase
    endfunction

endpackage

// File: rtl/vregs_exenum_ascii.sv
// Combinational 4-bit En_ExEnum to 8-character ASCII debug decoder.
module vregs_exenum_ascii
    import vregs_exenum_seq_pkg::*;
(
    input  logic [3:0]  exenum_i,
    output logic [63:0] ascii_o
);

    always_comb begin
        ascii_o = "%Error  ";
        case (exenum_i)
            EP_ExEnum_ONE:      ascii_o = "one     ";
            EP_ExEnum_TWO:      ascii_o = "two     ";
            EP_ExEnum_FIVE:     ascii_o = "five    ";
            EP_ExEnum_FOURTEEN: ascii_o = "fourteen";
            default:            ascii_o = "%Error  ";
        endcase
    end

endmodule

// File: rtl/vregs_exenum_seq.sv
// En_ExEnum sequencer: steps m_exenum_r with a programmable dwell per state,
// supports software force, graceful stop at a state boundary and a wrap pulse.
module vregs_exenum_seq
    import vregs_exenum_seq_pkg::*;
#(
    parameter int unsigned DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               force_vld,
    input  logic [3:0]         force_val,
    output logic [3:0]         m_exenum_r,
    output logic [63:0]        m_exenum_r_ascii,
    output logic               busy,
    output logic               wrap,
    output logic               err
);

    ex_enum_e           state_q, state_d;
    logic [DWELL_W-1:0] count_q, count_d;
    logic               busy_q, busy_d;
    logic               stop_pend_q, stop_pend_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic [DWELL_W-1:0] reload;

    // A dwell of 0 behaves as 1, so the reload value saturates at zero.
    assign reload = (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EP_ExEnum_ONE;
            count_q     <= '0;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            stop_pend_q <= stop_pend_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        busy_d      = busy_q;
        stop_pend_d = stop_pend_q;
        wrap_d      = 1'b0;
        err_d       = err_q;

        // A stop seen while running is remembered even across a force cycle.
        if (busy_q && stop) begin
            stop_pend_d = 1'b1;
        end

        if (force_vld) begin
            if (exenum_legal(force_val)) begin
                state_d = ex_enum_e'(force_val);
                count_d = reload;
            end else begin
                err_d = 1'b1;
            end
        end else if (busy_q) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                state_d = exenum_next(state_q);
                count_d = reload;
                wrap_d  = (state_q == EP_ExEnum_FOURTEEN);
                if (stop_pend_q || stop) begin
                    busy_d      = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
        end else if (start) begin
            busy_d      = 1'b1;
            count_d     = reload;
            stop_pend_d = stop;
        end
    end

    vregs_exenum_ascii u_ascii (
        .exenum_i (state_q),
        .ascii_o  (m_exenum_r_ascii)
    );

    assign m_exenum_r = state_q;
    assign busy       = busy_q;
    assign wrap       = wrap_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vregs_exenum_seq.sv
// Scoreboard bench for vregs_exenum_seq: directed scenarios plus random traffic,
// checked against a cycle-level reference model of the sequencing rules.
module tb_vregs_exenum_seq;

    typedef struct {
        logic [3:0]  st;
        logic        busy;
        logic        wrap;
        logic        err;
        logic [63:0] ascii;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cfg_dwell;
    logic        start;
    logic        stop;
    logic        force_vld;
    logic [3:0]  force_val;
    logic [3:0]  m_exenum_r;
    logic [63:0] m_exenum_r_ascii;
    logic        busy;
    logic        wrap;
    logic        err;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   drv_done = 1'b0;

    // Reference model: position in the ONE,TWO,FIVE,FOURTEEN ring plus
    // "edges left until the next advance".
    int seq_v[4] = '{1, 2, 5, 14};
    int m_state, m_left;
    bit m_busy, m_pend, m_err, m_wrap;

    always #5 clk = ~clk;

    vregs_exenum_seq #(.DWELL_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_dwell        (cfg_dwell),
        .start            (start),
        .stop             (stop),
        .force_vld        (force_vld),
        .force_val        (force_val),
        .m_exenum_r       (m_exenum_r),
        .m_exenum_r_ascii (m_exenum_r_ascii),
        .busy             (busy),
        .wrap             (wrap),
        .err              (err)
    );

    function automatic int idx_of(input int v);
        for (int i = 0; i < 4; i++) if (seq_v[i] == v) return i;
        return -1;
    endfunction

    function automatic logic [63:0] name_of(input int v);
        case (v)
            1:       return "one     ";
            2:       return "two     ";
            5:       return "five    ";
            14:      return "fourteen";
            default: return "%Error  ";
        endcase
    endfunction

    task automatic model_step(input bit r, input int cfg, input bit s, input bit p,
                              input bit f, input int fval);
        int d;
        int k;
        d = (cfg == 0) ? 1 : cfg;
        m_wrap = 1'b0;
        if (r) begin
            m_state = 1; m_left = 0; m_busy = 0; m_pend = 0; m_err = 0;
            return;
        end
        if (m_busy && p) m_pend = 1'b1;
        if (f) begin
            if (idx_of(fval) >= 0) begin
                m_state = fval;
                m_left  = d;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                k       = idx_of(m_state);
                m_wrap  = (k == 3);
                m_state = seq_v[(k + 1) % 4];
                m_left  = d;
                if (m_pend) begin
                    m_busy = 1'b0;
                    m_pend = 1'b0;
                end
            end
        end else if (s) begin
            m_busy = 1'b1;
            m_left = d;
            m_pend = p;
        end
    endtask

    // Apply one cycle of inputs, record the expected post-edge outputs, advance.
    task automatic drive(input bit r, input int cfg, input bit s, input bit p,
                         input bit f, input int fval);
        exp_t e;
        reset     = r;
        cfg_dwell = 8'(cfg);
        start     = s;
        stop      = p;
        force_vld = f;
        force_val = 4'(fval);
        model_step(r, cfg, s, p, f, fval);
        e.st    = 4'(m_state);
        e.busy  = m_busy;
        e.wrap  = m_wrap;
        e.err   = m_err;
        e.ascii = name_of(m_state);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int cfg);
        for (int i = 0; i < n; i++) drive(0, cfg, 0, 0, 0, 0);
    endtask

    // Monitor: compares DUT outputs after each edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() == 0) begin
                if (!drv_done) begin
                    n_miss++;
                    $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
                end
            end else begin
                e = exp_q.pop_front();
                n_vec++;
                if (m_exenum_r !== e.st) begin
                    n_miss++;
                    $display("FAIL state vec%0d: got %0d required %0d", n_vec, m_exenum_r, e.st);
                end
                if (m_exenum_r_ascii !== e.ascii) begin
                    n_miss++;
                    $display("FAIL ascii vec%0d: got \"%s\" required \"%s\"", n_vec, m_exenum_r_ascii, e.ascii);
                end
                if (busy !== e.busy) begin
                    n_miss++;
                    $display("FAIL busy vec%0d: got %b required %b", n_vec, busy, e.busy);
                end
                if (wrap !== e.wrap) begin
                    n_miss++;
                    $display("FAIL wrap vec%0d: got %b required %b", n_vec, wrap, e.wrap);
                end
                if (err !== e.err) begin
                    n_miss++;
                    $display("FAIL err vec%0d: got %b required %b", n_vec, err, e.err);
                end
            end
        end
    end

    initial begin
        int cfg;
        bit s, p, f;
        int fv;
        int illegal_v[4] = '{0, 3, 7, 15};

        // 1: dwell 3, full ring with wrap after edge 12
        drive(1, 3, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0);
        drive(0, 3, 1, 0, 0, 0);
        idle(14, 3);
        drive(0, 3, 0, 1, 0, 0);
        idle(4, 3);

        // 2: dwell 0 behaves as 1
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        idle(10, 0);
        drive(0, 0, 0, 1, 0, 0);
        idle(3, 0);

        // 3: stop mid-dwell completes at the next advance, then holds TWO
        drive(1, 4, 0, 0, 0, 0);
        drive(0, 4, 1, 0, 0, 0);
        idle(1, 4);
        drive(0, 4, 0, 1, 0, 0);
        idle(12, 4);

        // 4: legal then illegal force while idle; err sticky
        drive(0, 4, 0, 0, 1, 5);
        idle(2, 4);
        drive(0, 4, 0, 0, 1, 7);
        idle(4, 4);

        // 5: force FOURTEEN on a scheduled advance edge, next advance wraps
        drive(1, 2, 0, 0, 0, 0);
        drive(0, 2, 1, 0, 0, 0);
        idle(1, 2);
        drive(0, 2, 0, 0, 1, 14);
        idle(5, 2);

        // 6: reset mid-run with a pending stop; restart runs clean
        drive(1, 3, 0, 0, 0, 0);
        drive(0, 3, 1, 0, 0, 0);
        drive(0, 3, 0, 1, 0, 0);
        drive(1, 3, 0, 0, 0, 0);
        drive(0, 3, 1, 0, 0, 0);
        idle(14, 3);

        // Same-cycle start+stop while idle yields exactly one advance
        drive(1, 2, 0, 0, 0, 0);
        drive(0, 2, 1, 1, 0, 0);
        idle(6, 2);

        // Random traffic
        cfg = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) cfg = int'($urandom_range(0, 6));
            s = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 29) == 0);
            f = !s && ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 4) == 0) fv = illegal_v[$urandom_range(0, 3)];
            else fv = seq_v[$urandom_range(0, 3)];
            drive($urandom_range(0, 299) == 0, cfg, s, p, f, fv);
        end

        drv_done = 1'b1;
        repeat (3) @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
